bdd_walk_sequencer: RTL and testbench
=====================================

// Module: bdd_walk_sequencer
// PURPOSE
//  Sequential evaluator for one output bit of the generated select-tree logic.
//  The tree is held as a decision-diagram node table. The block walks the table one node per cycle against a captured input vector.
//  Tables are loaded through a config write port, so one small engine can time-share many output bits instead of instantiating a flat mux tree per bit.
//  It sits between the bit-scheduler (requester) and the result collector.
// PARAMETERS
//  IN_W      1894  width of the input vector under evaluation
//  VAR_W     11    width of the node variable index (2**VAR_W >= IN_W)
//  NODE_AW   8     node table address width (2**NODE_AW nodes)
//  MAX_STEPS 64    node visits before a walk is aborted as cyclic
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst_n      in   1                  synchronous reset, active low
//  cfg_we     in   1                  node table write strobe
//  cfg_addr   in   NODE_AW            node table write address
//  cfg_wdata  in   VAR_W+2*(NODE_AW+1)  {var, lo_ptr, hi_ptr}
//  cfg_err    out  1                  1-cycle pulse: write dropped, engine busy
//  req_valid  in   1                  evaluation request
//  req_ready  out  1                  engine can accept a request
//  req_vec    in   IN_W               input vector, captured on accept
//  req_root   in   NODE_AW+1          starting pointer
//  rsp_valid  out  1                  result available
//  rsp_ready  in   1                  collector accepts result
//  rsp_bit    out  1                  evaluated output bit
//  rsp_err    out  1                  walk aborted (bad var index or MAX_STEPS)
//  rsp_steps  out  7                  internal nodes visited
// BEHAVIOUR
//  Pointer format: MSB=1 means terminal, and LSB is the terminal value. MSB=0 means a node address.
//  Node semantics: next = vec[var] ? hi_ptr : lo_ptr.
//  Reset (rst_n=0 at edge): state IDLE; req_ready=1.
//   rsp_valid, rsp_bit, rsp_err, rsp_steps, cfg_err all 0.
//   The node table is NOT cleared.
//   A reset during WALK or DONE abandons the walk with no response.
//  FSM IDLE -> WALK -> DONE -> IDLE:
//   IDLE: req_ready=1. On req_valid: capture req_vec, ptr<=req_root, steps<=0, go to WALK.
//   WALK: the table is read asynchronously at ptr[NODE_AW-1:0].
//    If ptr is terminal: rsp_bit<=ptr[0], rsp_err<=0, go to DONE.
//    Else if var>=IN_W: rsp_bit<=0, rsp_err<=1, go to DONE.
//    Else if steps==MAX_STEPS: rsp_bit<=0, rsp_err<=1, go to DONE.
//    Else: ptr<=selected child, steps<=steps+1.
//   DONE: rsp_valid=1. rsp_bit, rsp_err and rsp_steps are held stable until rsp_ready. When rsp_ready=1, go to IDLE.
//  Latency: accept handshake in cycle 0 with n internal nodes -> rsp_valid first high in cycle n+2.
//   A terminal root gives rsp_valid in cycle 2 with steps=0.
//   The earliest next accept is the cycle after the rsp handshake.
//  req_ready is 0 in WALK and DONE. req_vec is ignored outside the accept cycle.
//  rsp_steps saturates by construction: MAX_STEPS <= 127.
//  Config writes:
//   A write is performed only when state==IDLE. It takes effect at the edge.
//   A write in WALK or DONE is dropped, and cfg_err pulses for exactly one cycle.
//   A write and a request in the same IDLE cycle: both are taken. The walk sees the new word.
// TESTING
//  Load node0={var=63,lo=T0,hi=node1} and node1={var=1713,lo=T0,hi=T1}.
//   vec[63]=1, vec[1713]=1, root=0 -> bit=1, err=0, steps=2, rsp_valid in cycle 4.
//  Same table, vec[63]=0 -> bit=0, steps=1, rsp_valid in cycle 3.
//   Then hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
//  root=T1 (terminal) -> bit=1, steps=0, rsp_valid in cycle 2.
//   Also node0.var=2000 -> err=1, bit=0.
//  Self-loop node0={var=5,lo=node0,hi=node0} -> err=1, steps=64 after 65 WALK cycles.
//  cfg_we during WALK -> cfg_err pulses 1 cycle and the table is unchanged (read back by walk).
//   rst_n=0 mid-WALK -> next cycle IDLE, req_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/bdd_walk_sequencer.sv
// ---------------------------------------------------------------------------
// bdd_walk_sequencer
//
// Purpose:
//   Sequential evaluator for one output bit of a select tree stored as a
//   binary decision diagram. A node table is loaded through a config write
//   port. Each request captures an input vector and a root pointer. The
//   engine then walks the table, visiting one node per clock, until it
//   reaches a terminal pointer or aborts.
//
// Pointer format (NODE_AW+1 bits):
//   MSB = 1 : terminal; LSB carries the terminal value.
//   MSB = 0 : low NODE_AW bits are a node address.
//
// Node word format:
//   {var[VAR_W-1:0], lo_ptr, hi_ptr}
//   next = vec[var] ? hi_ptr : lo_ptr
//
// Ports:
//   clk        clock; all logic is on the rising edge
//   rst_n      synchronous reset, active low (the node table is not cleared)
//   cfg_we     node table write strobe; honoured only while idle
//   cfg_addr   node table write address
//   cfg_wdata  node word {var, lo_ptr, hi_ptr}
//   cfg_err    one-cycle pulse: a write was dropped because the engine was busy
//   req_valid  evaluation request
//   req_ready  engine can accept a request (idle)
//   req_vec    input vector; captured only on accept
//   req_root   starting pointer
//   rsp_valid  result available; held until rsp_ready
//   rsp_ready  collector accepts the result
//   rsp_bit    evaluated output bit
//   rsp_err    walk aborted (variable index out of range, or step limit hit)
//   rsp_steps  number of internal nodes visited
// ---------------------------------------------------------------------------
module bdd_walk_sequencer #(
    parameter int IN_W      = 1894,
    parameter int VAR_W     = 11,
    parameter int NODE_AW   = 8,
    parameter int MAX_STEPS = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_we,
    input  logic [NODE_AW-1:0]               cfg_addr,
    input  logic [VAR_W+2*(NODE_AW+1)-1:0]   cfg_wdata,
    output logic                             cfg_err,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [IN_W-1:0]                  req_vec,
    input  logic [NODE_AW:0]                 req_root,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_bit,
    output logic                             rsp_err,
    output logic [6:0]                       rsp_steps
);

    localparam int PTR_W  = NODE_AW + 1;
    localparam int WORD_W = VAR_W + 2 * PTR_W;
    localparam int NODES  = 1 << NODE_AW;

    // One extra bit so the range check also works when IN_W == 2**VAR_W.
    localparam logic [VAR_W:0] IN_W_EXT   = (VAR_W + 1)'(IN_W);
    localparam logic [6:0]     STEP_LIMIT = 7'(MAX_STEPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [6:0]        steps_reg;
    logic [IN_W-1:0]   vec_reg;
    logic              rsp_bit_reg;
    logic              rsp_err_reg;
    logic              cfg_err_reg;

    // Node table. Read combinationally so a node is resolved in the same
    // cycle its pointer is presented; no reset, contents survive rst_n.
    logic [WORD_W-1:0] node_mem [NODES];

    logic [WORD_W-1:0] node_word;
    logic [VAR_W-1:0]  node_var;
    logic [PTR_W-1:0]  node_lo;
    logic [PTR_W-1:0]  node_hi;
    logic              ptr_is_term;
    logic              var_ok;
    logic              sel_bit;
    logic [PTR_W-1:0]  child_ptr;
    logic              write_ok;

    assign write_ok = cfg_we && (state_reg == S_IDLE);

    always_ff @(posedge clk) begin
        if (write_ok) begin
            node_mem[cfg_addr] <= cfg_wdata;
        end
    end

    assign node_word   = node_mem[ptr_reg[NODE_AW-1:0]];
    assign node_var    = node_word[WORD_W-1 -: VAR_W];
    assign node_lo     = node_word[2*PTR_W-1 -: PTR_W];
    assign node_hi     = node_word[PTR_W-1:0];
    assign ptr_is_term = ptr_reg[PTR_W-1];
    assign var_ok      = ({1'b0, node_var} < IN_W_EXT);
    // Guard the select so an out-of-range index never reaches the vector.
    assign sel_bit     = var_ok ? vec_reg[node_var] : 1'b0;
    assign child_ptr   = sel_bit ? node_hi : node_lo;

    // The vector is only meaningful during a walk, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_reg == S_IDLE && req_valid) begin
            vec_reg <= req_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            ptr_reg     <= '0;
            steps_reg   <= '0;
            rsp_bit_reg <= 1'b0;
            rsp_err_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_we && (state_reg != S_IDLE);
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        ptr_reg   <= req_root;
                        steps_reg <= '0;
                        state_reg <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (ptr_is_term) begin
                        rsp_bit_reg <= ptr_reg[0];
                        rsp_err_reg <= 1'b0;
                        state_reg   <= S_DONE;
                    end else if (!var_ok || steps_reg == STEP_LIMIT) begin
                        rsp_bit_reg <= 1'b0;
                        rsp_err_reg <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        ptr_reg   <= child_ptr;
                        steps_reg <= steps_reg + 7'd1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == S_IDLE);
    assign rsp_valid = (state_reg == S_DONE);
    assign rsp_bit   = rsp_bit_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_steps = steps_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_bdd_walk_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bdd_walk_sequencer
//
// Self-checking bench for bdd_walk_sequencer. A behavioural model keeps its
// own copy of the node table and evaluates each walk as a plain loop over
// pointers. Directed cases cover the documented scenarios; a randomized
// phase then loads random tables and vectors.
// ---------------------------------------------------------------------------
module tb_bdd_walk_sequencer;

    localparam int IN_W      = 1894;
    localparam int VAR_W     = 11;
    localparam int NODE_AW   = 8;
    localparam int MAX_STEPS = 64;
    localparam int WORD_W    = VAR_W + 2 * (NODE_AW + 1);
    localparam int WAIT_MAX  = 200;

    localparam logic [8:0] T0 = 9'h100;
    localparam logic [8:0] T1 = 9'h101;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_we;
    logic [NODE_AW-1:0]  cfg_addr;
    logic [WORD_W-1:0]   cfg_wdata;
    logic                cfg_err;
    logic                req_valid;
    logic                req_ready;
    logic [IN_W-1:0]     req_vec;
    logic [NODE_AW:0]    req_root;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_bit;
    logic                rsp_err;
    logic [6:0]          rsp_steps;

    int total = 0;
    int bad   = 0;

    logic [WORD_W-1:0] tbl [256];

    always #5 clk = ~clk;

    bdd_walk_sequencer #(
        .IN_W      (IN_W),
        .VAR_W     (VAR_W),
        .NODE_AW   (NODE_AW),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vec   (req_vec),
        .req_root  (req_root),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_bit   (rsp_bit),
        .rsp_err   (rsp_err),
        .rsp_steps (rsp_steps)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk_node(input int v, input logic [8:0] lo, input logic [8:0] hi);
        logic [VAR_W-1:0] vv;
        vv = VAR_W'(v);
        return {vv, lo, hi};
    endfunction

    function automatic logic [8:0] nptr(input int n);
        return {1'b0, 8'(n)};
    endfunction

    // Reference: follow pointers until a terminal, a bad index or the step limit.
    task automatic model_walk(input logic [IN_W-1:0] vec, input logic [8:0] root,
                              output logic b, output logic e, output int s);
        logic [8:0]        p;
        logic [WORD_W-1:0] w;
        int                v;
        p = root;
        s = 0;
        b = 1'b0;
        e = 1'b0;
        for (int guard = 0; guard < 1000; guard++) begin
            if (p[8]) begin
                b = p[0];
                e = 1'b0;
                return;
            end
            w = tbl[p[7:0]];
            v = int'(w[WORD_W-1 -: VAR_W]);
            if (v >= IN_W || s == MAX_STEPS) begin
                b = 1'b0;
                e = 1'b1;
                return;
            end
            p = vec[v] ? w[8:0] : w[17:9];
            s++;
        end
    endtask

    // Called and returns at posedge+1 with the engine idle.
    task automatic set_node(input int addr, input logic [WORD_W-1:0] word);
        cfg_we    = 1'b1;
        cfg_addr  = 8'(addr);
        cfg_wdata = word;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tbl[addr] = word;
        check_val("cfg_err_idle_write", 32'(cfg_err), 0);
    endtask

    function automatic logic [IN_W-1:0] rand_vec();
        logic [IN_W-1:0] v;
        for (int i = 0; i < IN_W; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < WAIT_MAX) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("rsp_valid_after_hs", 32'(rsp_valid), 0);
        check_val("req_ready_after_hs", 32'(req_ready), 1);
    endtask

    task automatic do_walk(input logic [IN_W-1:0] vec, input logic [8:0] root, input int hold,
                           input bit wr_en, input int wr_addr, input logic [WORD_W-1:0] wr_data);
        logic eb, ee;
        int   es, lat;
        logic [6:0] hs;
        logic hb, he;
        if (wr_en) tbl[wr_addr] = wr_data;
        model_walk(vec, root, eb, ee, es);
        check_val("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_vec   = vec;
        req_root  = root;
        cfg_we    = wr_en;
        cfg_addr  = 8'(wr_addr);
        cfg_wdata = wr_data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cfg_we    = 1'b0;
        req_vec   = ~vec;
        check_val("req_ready_walk", 32'(req_ready), 0);
        wait_rsp(lat);
        check_val("latency", 32'(lat), 32'(es + 2));
        check_val("rsp_bit", 32'(rsp_bit), 32'(eb));
        check_val("rsp_err", 32'(rsp_err), 32'(ee));
        check_val("rsp_steps", 32'(rsp_steps), 32'(es));
        $display("walk root=%03h bit=%0d err=%0d steps=%0d lat=%0d exp_lat=%0d",
                 root, rsp_bit, rsp_err, rsp_steps, lat, es + 2);
        hb = rsp_bit;
        he = rsp_err;
        hs = rsp_steps;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 32'(rsp_valid), 1);
            check_val("hold_ready", 32'(req_ready), 0);
            check_val("hold_bit", 32'(rsp_bit), 32'(hb));
            check_val("hold_err", 32'(rsp_err), 32'(he));
            check_val("hold_steps", 32'(rsp_steps), 32'(hs));
        end
        finish_rsp();
    endtask

    initial begin
        logic [IN_W-1:0] v;
        int lat;

        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        req_valid = 1'b0;
        req_vec   = '0;
        req_root  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 0);
        check_val("rst_rsp_bit", 32'(rsp_bit), 0);
        check_val("rst_rsp_err", 32'(rsp_err), 0);
        check_val("rst_rsp_steps", 32'(rsp_steps), 0);
        check_val("rst_cfg_err", 32'(cfg_err), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) set_node(i, mk_node(0, T0, T1));

        // Two-level chain through var 63 and var 1713.
        set_node(0, mk_node(63, T0, nptr(1)));
        set_node(1, mk_node(1713, T0, T1));
        v = '0; v[63] = 1'b1; v[1713] = 1'b1;
        do_walk(v, nptr(0), 0, 1'b0, 0, '0);
        v[63] = 1'b0;
        do_walk(v, nptr(0), 5, 1'b0, 0, '0);

        // Terminal roots and a bad variable index.
        do_walk(v, T1, 0, 1'b0, 0, '0);
        do_walk(v, T0, 0, 1'b0, 0, '0);
        set_node(0, mk_node(2000, T1, T1));
        do_walk(v, nptr(0), 0, 1'b0, 0, '0);
        set_node(0, mk_node(1894, T1, T1));
        do_walk(v, nptr(0), 0, 1'b0, 0, '0);
        set_node(0, mk_node(1893, T0, T1));
        v[1893] = 1'b1;
        do_walk(v, nptr(0), 0, 1'b0, 0, '0);

        // Self-loop: aborts once the step limit is reached.
        set_node(0, mk_node(5, nptr(0), nptr(0)));
        do_walk(v, nptr(0), 0, 1'b0, 0, '0);

        // Config write while walking is dropped with a one-cycle cfg_err.
        req_valid = 1'b1;
        req_root  = nptr(0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("cfg_err_before", 32'(cfg_err), 0);
        cfg_we    = 1'b1;
        cfg_addr  = 8'd0;
        cfg_wdata = mk_node(5, T1, T1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check_val("cfg_err_pulse", 32'(cfg_err), 1);
        @(posedge clk); #1;
        check_val("cfg_err_one_cycle", 32'(cfg_err), 0);
        wait_rsp(lat);
        check_val("busy_wr_valid", 32'(rsp_valid), 1);
        check_val("busy_wr_err", 32'(rsp_err), 1);
        check_val("busy_wr_steps", 32'(rsp_steps), MAX_STEPS);
        $display("walk busy-write steps=%0d err=%0d", rsp_steps, rsp_err);
        finish_rsp();
        do_walk(v, nptr(0), 0, 1'b0, 0, '0);

        // Reset during a walk abandons it.
        req_valid = 1'b1;
        req_root  = nptr(0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("midrst_req_ready", 32'(req_ready), 1);
        check_val("midrst_rsp_valid", 32'(rsp_valid), 0);
        check_val("midrst_rsp_steps", 32'(rsp_steps), 0);
        check_val("midrst_rsp_err", 32'(rsp_err), 0);
        $display("reset mid-walk req_ready=%0d rsp_valid=%0d", req_ready, rsp_valid);
        // Table survives reset.
        do_walk(v, nptr(0), 0, 1'b0, 0, '0);

        // Write and request in the same idle cycle: walk sees the new word.
        do_walk(v, nptr(0), 0, 1'b1, 0, mk_node(5, T1, T1));

        // Randomized tables and vectors.
        for (int it = 0; it < 40; it++) begin
            int nwr;
            logic [8:0] root;
            nwr = (it == 0) ? 32 : int'($urandom_range(1, 4));
            for (int k = 0; k < nwr; k++) begin
                int a, vi;
                logic [8:0] lo, hi;
                a  = (it == 0) ? k : int'($urandom_range(0, 31));
                vi = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2047))
                                                  : int'($urandom_range(0, IN_W - 1));
                lo = ($urandom_range(0, 2) == 0) ? {1'b1, 7'd0, 1'($urandom_range(0, 1))}
                                                 : nptr(int'($urandom_range(0, 31)));
                hi = ($urandom_range(0, 2) == 0) ? {1'b1, 7'd0, 1'($urandom_range(0, 1))}
                                                 : nptr(int'($urandom_range(0, 31)));
                set_node(a, mk_node(vi, lo, hi));
            end
            root = ($urandom_range(0, 9) == 0) ? {1'b1, 7'd0, 1'($urandom_range(0, 1))}
                                               : nptr(int'($urandom_range(0, 31)));
            do_walk(rand_vec(), root, int'($urandom_range(0, 2)), 1'b0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
